priority_encoder_stream: RTL and testbench

// - Inverse of the team's one-hot decoders: accepts an N-bit request vector and emits, one

---
 rtl/priority_encoder_stream.sv | 136 +++++++++++++
 tb/tb_priority_encoder_stream.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_stream.sv
// priority_encoder_stream
//   Takes an N-bit request vector and streams out the binary code of every set bit,
//   highest bit first. Code k corresponds to vector bit N-1-k, which matches the
//   one-hot decoder mapping, so decoding each emitted code rebuilds the vector.
//   An all-zero vector produces one beat with out_zero=1.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake; in_vec is captured on in_valid & in_ready
//   in_vec   [N-1:0]       request vector
//   out_valid/out_ready    output handshake
//   out_code [W-1:0]       code of the current highest pending bit
//   out_last               current beat is the last for this vector
//   out_zero               accepted vector had no set bits
module priority_encoder_stream #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         out_zero
);

  if (N < 2 || W != $clog2(N)) begin : g_param_check
    $error("priority_encoder_stream: need N >= 2 and W == $clog2(N)");
  end

  typedef enum logic {IDLE, EMIT} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         vld_q, vld_d;
  logic [W-1:0] code_q, code_d;
  logic         last_q, last_d;
  logic         zero_q, zero_d;

  // Code of the highest set bit; ascending scan so the highest hit wins.
  // Returns 0 for an all-zero vector.
  function automatic logic [W-1:0] code_of(input logic [N-1:0] v);
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) c = W'(N - 1 - i);
    return c;
  endfunction

  function automatic logic single_bit(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  function automatic logic [N-1:0] clr_msb(input logic [N-1:0] v);
    logic [N-1:0] r;
    logic         found;
    r     = v;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i] && !found) begin
        r[i]  = 1'b0;
        found = 1'b1;
      end
    return r;
  endfunction

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = vld_q;
  assign out_code  = code_q;
  assign out_last  = last_q;
  assign out_zero  = zero_q;

  // Beat fields are computed one cycle ahead from the next pending value so the
  // outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    vld_d   = vld_q;
    code_d  = code_q;
    last_d  = last_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          pend_d  = in_vec;
          vld_d   = 1'b1;
          code_d  = code_of(in_vec);
          zero_d  = (in_vec == '0);
          last_d  = (in_vec == '0) || single_bit(in_vec);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            // Return to IDLE; in_ready rises next cycle, so no overlap with the last beat.
            state_d = IDLE;
            pend_d  = '0;
            vld_d   = 1'b0;
            code_d  = '0;
            last_d  = 1'b0;
            zero_d  = 1'b0;
          end else begin
            pend_d  = clr_msb(pend_q);
            code_d  = code_of(pend_d);
            last_d  = single_bit(pend_d);
            zero_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      vld_q   <= 1'b0;
      code_q  <= '0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder_stream.sv
// Bench for priority_encoder_stream (N=4). A scoreboard process queues the expected
// beats for every accepted vector and checks each output handshake; scenario tasks
// add inline timing checks.
module tb_priority_encoder_stream;

  localparam int N = 4;
  localparam int W = 2;

  typedef struct packed {
    logic [W-1:0] code;
    logic         last;
    logic         zero;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_vec = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_code;
  logic         out_last;
  logic         out_zero;

  int checks = 0;
  int errors = 0;
  bit rnd    = 1'b0;

  beat_t        exp_q[$];
  logic [N-1:0] vec_q[$];
  logic [N-1:0] acc = '0;

  always #5 clk = ~clk;

  priority_encoder_stream #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_last(out_last), .out_zero(out_zero)
  );

  // Scoreboard: sampled on the falling edge, i.e. with the values the next rising
  // edge will act on.
  task automatic monitor();
    beat_t        e;
    beat_t        b;
    logic [N-1:0] v;
    logic [N-1:0] lower;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        vec_q.delete();
        acc = '0;
      end else begin
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got code=%0d last=%0b zero=%0b, expected none",
                     out_code, out_last, out_zero);
          end else begin
            e = exp_q.pop_front();
            if ({out_code, out_last, out_zero} !== e) begin
              errors++;
              $display("FAIL beat: got code=%0d last=%0b zero=%0b, expected code=%0d last=%0b zero=%0b",
                       out_code, out_last, out_zero, e.code, e.last, e.zero);
            end
          end
          if (!out_zero) acc = acc | (N'(1) << (N - 1 - int'(out_code)));
          if (out_last) begin
            checks++;
            v = (vec_q.size() != 0) ? vec_q.pop_front() : 'x;
            if (acc !== v) begin
              errors++;
              $display("FAIL rebuild: got %b, expected %b", acc, v);
            end
            acc = '0;
          end
        end
        if (in_valid && in_ready) begin
          vec_q.push_back(in_vec);
          if (in_vec == '0) begin
            b.code = '0; b.last = 1'b1; b.zero = 1'b1;
            exp_q.push_back(b);
          end else begin
            for (int k = N - 1; k >= 0; k--) begin
              if (in_vec[k]) begin
                lower  = in_vec & ((N'(1) << k) - N'(1));
                b.code = W'(N - 1 - k);
                b.last = (lower == '0);
                b.zero = 1'b0;
                exp_q.push_back(b);
              end
            end
          end
        end
      end
    end
  endtask

  // Advance to just after the next rising edge; optionally randomise backpressure.
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present v until accepted; returns just after the accepting edge.
  task automatic send(input logic [N-1:0] v);
    bit ok;
    ok       = 1'b0;
    in_vec   = v;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: vector %b never accepted", v);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready && (exp_q.size() == 0);
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: in_ready=%0b pending_beats=%0d", in_ready, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++;
    if ({out_valid, out_code, out_last, out_zero, in_ready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b code=%0d last=%0b zero=%0b ready=%0b, expected all 0",
               out_valid, out_code, out_last, out_zero, in_ready);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b, expected 1", in_ready);
    end
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(4'b1000);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: got valid=%0b ready=%0b, expected valid=1 ready=0", out_valid, in_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_return: got ready=%0b valid=%0b, expected ready=1 valid=0", in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_multi();
    logic [W-1:0] codes [3];
    codes[0] = 2'd0; codes[1] = 2'd2; codes[2] = 2'd3;
    out_ready = 1'b1;
    send(4'b1011);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_code !== codes[i] || out_last !== (i == 2)) begin
        errors++;
        $display("FAIL multi_beat%0d: got valid=%0b code=%0d last=%0b, expected valid=1 code=%0d last=%0b",
                 i, out_valid, out_code, out_last, codes[i], (i == 2));
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL multi_return: got ready=%0b, expected 1", in_ready);
    end
    step();
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    send(4'b0000);
    @(negedge clk);
    checks++;
    if ({out_valid, out_code, out_last, out_zero} !== 5'b1_00_1_1) begin
      errors++;
      $display("FAIL zero_beat: got valid=%0b code=%0d last=%0b zero=%0b, expected 1 0 1 1",
               out_valid, out_code, out_last, out_zero);
    end
    step();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_return: got ready=%0b valid=%0b, expected 1 0", in_ready, out_valid);
    end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'b0110);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_code, out_last, out_zero} !== 5'b1_01_0_0) begin
        errors++;
        $display("FAIL hold%0d: got valid=%0b code=%0d last=%0b zero=%0b, expected 1 1 0 0",
                 i, out_valid, out_code, out_last, out_zero);
      end
      if (i < 2) step();
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_code !== 2'd1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: got code=%0d last=%0b, expected 1 0", out_code, out_last);
    end
    step();
    @(negedge clk);
    checks++;
    if (out_code !== 2'd2 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got code=%0d last=%0b, expected 2 1", out_code, out_last);
    end
    step();
    wait_idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(4'b1111);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_code !== 2'd0) begin
      errors++;
      $display("FAIL rm_first: got valid=%0b code=%0d, expected 1 0", out_valid, out_code);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_flush: got valid=%0b ready=%0b, expected 0 1", out_valid, in_ready);
    end
    step();
    send(4'b0001);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_code !== 2'd3 || out_last !== 1'b1) begin
      errors++;
      $display("FAIL rm_new: got valid=%0b code=%0d last=%0b, expected 1 3 1", out_valid, out_code, out_last);
    end
    step();
    wait_idle();
  endtask

  task automatic test_hold_input();
    out_ready = 1'b1;
    in_vec    = 4'b0011;
    in_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_accept: got ready=%0b, expected 1", in_ready);
    end
    step();
    in_vec = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== (i == 2)) begin
        errors++;
        $display("FAIL hold_ready%0d: got %0b, expected %0b", i, in_ready, (i == 2));
      end
      step();
    end
    in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_random();
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(N'($urandom_range(0, (1 << N) - 1)));
      if (($urandom_range(0, 3)) == 0) step();
    end
    rnd       = 1'b0;
    out_ready = 1'b1;
    wait_idle();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_hold_input();
    test_random();
    checks++;
    if (exp_q.size() != 0 || vec_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d beats / %0d vectors outstanding, expected 0",
               exp_q.size(), vec_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
